pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 126 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with stall / flush / bubble control, a sticky
// stall timeout flag and optional bubble/stall performance counters.
// Optional feature macro: PIPE_STAGE_PERF_CNT_EN (enables bubble_cnt / stall_cnt).
module pipe_stage_reg #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned CTRL_W      = 8,
    parameter int unsigned STALL_LIMIT = 64,
    parameter int unsigned CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              bubble,
    input  logic              in_valid,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              out_valid,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic [DATA_W-1:0] data_out,
    output logic              stall_timeout,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int unsigned RUN_W = $clog2(STALL_LIMIT + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STALL_LIMIT);

    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic              timeout_q, timeout_d;

    // Stage payload next-state: flush > stall > bubble > load
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else if (!stall) begin
            if (bubble) begin
                valid_d = 1'b0;
                ctrl_d  = '0;
                data_d  = data_in;
            end else begin
                valid_d = in_valid;
                ctrl_d  = in_valid ? ctrl_in : '0;
                data_d  = data_in;
            end
        end
    end

    // Saturating stall-run counter and sticky timeout, both cleared by flush
    always_comb begin
        run_d     = '0;
        timeout_d = timeout_q;
        if (flush) begin
            timeout_d = 1'b0;
        end else if (stall) begin
            run_d = (run_q == RUN_MAX) ? run_q : run_q + RUN_W'(1);
            if (run_d == RUN_MAX) begin
                timeout_d = 1'b1;
            end
        end
    end

    // Stage and stall-tracking state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            ctrl_q    <= '0;
            data_q    <= '0;
            run_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            ctrl_q    <= ctrl_d;
            data_q    <= data_d;
            run_q     <= run_d;
            timeout_q <= timeout_d;
        end
    end

    assign out_valid     = valid_q;
    assign ctrl_out      = ctrl_q;
    assign data_out      = data_q;
    assign stall_timeout = timeout_q;

`ifdef PIPE_STAGE_PERF_CNT_EN
    logic [CNT_W-1:0] bub_cnt_q, bub_cnt_d;
    logic [CNT_W-1:0] stl_cnt_q, stl_cnt_d;

    // Saturating counters; flush+stall counts only as a flush
    always_comb begin
        bub_cnt_d = bub_cnt_q;
        stl_cnt_d = stl_cnt_q;
        if ((flush || (bubble && !stall)) && (bub_cnt_q != '1)) begin
            bub_cnt_d = bub_cnt_q + CNT_W'(1);
        end
        if (stall && !flush && (stl_cnt_q != '1)) begin
            stl_cnt_d = stl_cnt_q + CNT_W'(1);
        end
    end

    // Performance counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bub_cnt_q <= '0;
            stl_cnt_q <= '0;
        end else begin
            bub_cnt_q <= bub_cnt_d;
            stl_cnt_q <= stl_cnt_d;
        end
    end

    assign bubble_cnt = bub_cnt_q;
    assign stall_cnt  = stl_cnt_q;
`else
    assign bubble_cnt = '0;
    assign stall_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: vector table through a scoreboard queue, then
// hand sequences for bubble/stall hold, timeout, saturation and async reset.
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        stall, flush, bubble, in_valid;
    logic [7:0]  ctrl_in;
    logic [31:0] data_in;
    logic        out_valid;
    logic [7:0]  ctrl_out;
    logic [31:0] data_out;
    logic        stall_timeout;
    logic [3:0]  bubble_cnt, stall_cnt;

    pipe_stage_reg #(
        .DATA_W(32), .CTRL_W(8), .STALL_LIMIT(4), .CNT_W(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .bubble(bubble),
        .in_valid(in_valid), .ctrl_in(ctrl_in), .data_in(data_in),
        .out_valid(out_valid), .ctrl_out(ctrl_out), .data_out(data_out),
        .stall_timeout(stall_timeout), .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        s, f, b, v;
        logic [7:0]  c;
        logic [31:0] d;
        logic        e_v;
        logic [7:0]  e_c;
        logic [31:0] e_d;
        logic        e_to;
    } vec_t;

    typedef struct {
        logic        v;
        logic [7:0]  c;
        logic [31:0] d;
        logic        to;
        logic [3:0]  bc;
        logic [3:0]  sc;
    } exp_t;

    vec_t tbl[14];
    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   m_bub = 0;
    int   m_stl = 0;

    function automatic vec_t mk(input logic s, f, b, v, input logic [7:0] c,
                                input logic [31:0] d, input logic e_v,
                                input logic [7:0] e_c, input logic [31:0] e_d,
                                input logic e_to);
        vec_t r;
        r.s = s; r.f = f; r.b = b; r.v = v; r.c = c; r.d = d;
        r.e_v = e_v; r.e_c = e_c; r.e_d = e_d; r.e_to = e_to;
        return r;
    endfunction

    function automatic logic [3:0] ecnt(input int m);
        return PERF ? ((m > 15) ? 4'hF : 4'(m)) : 4'h0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, f, b, v, input logic [7:0] c, input logic [31:0] d);
        stall = s; flush = f; bubble = b; in_valid = v; ctrl_in = c; data_in = d;
        if (f)      m_bub++;
        else if (s) m_stl++;
        else if (b) m_bub++;
    endtask

    task automatic step(input logic s, f, b, v, input logic [7:0] c, input logic [31:0] d);
        drive(s, f, b, v, c, d);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".valid"},   32'(out_valid), 32'h0);
        chk({tag, ".ctrl"},    32'(ctrl_out), 32'h0);
        chk({tag, ".data"},    data_out, 32'h0);
        chk({tag, ".timeout"}, 32'(stall_timeout), 32'h0);
        chk({tag, ".bub_cnt"}, 32'(bubble_cnt), 32'h0);
        chk({tag, ".stl_cnt"}, 32'(stall_cnt), 32'h0);
    endtask

    // Reset mid low-phase; outputs must clear without a clock edge
    task automatic do_reset(input string tag);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        rst_n = 1'b0;
        m_bub = 0;
        m_stl = 0;
        #1;
        chk_zero(tag);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        exp_t e;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        m_bub = 0;
        m_stl = 0;

        //            s     f     b     v     ctrl   data           e_v   e_c    e_d            e_to
        tbl[0]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 32'h1234_5678, 1'b1, 8'hA5, 32'h1234_5678, 1'b0);
        tbl[1]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 32'h1111_1111, 1'b0, 8'h00, 32'h1111_1111, 1'b0);
        tbl[2]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 32'hCAFE_F00D, 1'b1, 8'h3C, 32'hCAFE_F00D, 1'b0);
        tbl[3]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 8'h77, 32'h0000_0000, 1'b1, 8'h3C, 32'hCAFE_F00D, 1'b0);
        tbl[4]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 8'h55, 32'hDEAD_BEEF, 1'b0, 8'h00, 32'hDEAD_BEEF, 1'b0);
        tbl[5]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 32'h0000_0001, 1'b0, 8'h00, 32'hDEAD_BEEF, 1'b0);
        tbl[6]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 8'h02, 32'h0000_0002, 1'b0, 8'h00, 32'hDEAD_BEEF, 1'b0);
        tbl[7]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 8'h03, 32'h0000_0003, 1'b0, 8'h00, 32'hDEAD_BEEF, 1'b0);
        tbl[8]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 8'h81, 32'h0BAD_C0DE, 1'b1, 8'h81, 32'h0BAD_C0DE, 1'b0);
        tbl[9]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 8'h66, 32'h6666_6666, 1'b0, 8'h00, 32'h0BAD_C0DE, 1'b0);
        tbl[10] = mk(1'b0, 1'b0, 1'b0, 1'b1, 8'h42, 32'h0000_0042, 1'b1, 8'h42, 32'h0000_0042, 1'b0);
        tbl[11] = mk(1'b0, 1'b1, 1'b1, 1'b1, 8'h99, 32'h9999_9999, 1'b0, 8'h00, 32'h0000_0042, 1'b0);
        tbl[12] = mk(1'b1, 1'b0, 1'b1, 1'b1, 8'hAA, 32'hAAAA_AAAA, 1'b0, 8'h00, 32'h0000_0042, 1'b0);
        tbl[13] = mk(1'b0, 1'b0, 1'b0, 1'b1, 8'h0F, 32'hF0F0_F0F0, 1'b1, 8'h0F, 32'hF0F0_F0F0, 1'b0);

        // Table vectors through the scoreboard
        do_reset("rst0");
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].s, tbl[i].f, tbl[i].b, tbl[i].v, tbl[i].c, tbl[i].d);
            e.v = tbl[i].e_v; e.c = tbl[i].e_c; e.d = tbl[i].e_d; e.to = tbl[i].e_to;
            e.bc = ecnt(m_bub); e.sc = ecnt(m_stl);
            sbq.push_back(e);
            @(posedge clk);
            #1;
            e = sbq.pop_front();
            chk($sformatf("vec%0d.valid", i),   32'(out_valid), 32'(e.v));
            chk($sformatf("vec%0d.ctrl", i),    32'(ctrl_out), 32'(e.c));
            chk($sformatf("vec%0d.data", i),    data_out, e.d);
            chk($sformatf("vec%0d.timeout", i), 32'(stall_timeout), 32'(e.to));
            chk($sformatf("vec%0d.bub_cnt", i), 32'(bubble_cnt), 32'(e.bc));
            chk($sformatf("vec%0d.stl_cnt", i), 32'(stall_cnt), 32'(e.sc));
        end

        // Bubble followed by a three-cycle stall holds the bubble contents
        do_reset("rstA");
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'h5A, 32'hDEAD_BEEF);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, 1'b1, 8'hC3, 32'h0000_1000 + 32'(k));
        chk("bubstall.valid",   32'(out_valid), 32'h0);
        chk("bubstall.ctrl",    32'(ctrl_out), 32'h0);
        chk("bubstall.data",    data_out, 32'hDEAD_BEEF);
        chk("bubstall.stl_cnt", 32'(stall_cnt), 32'(PERF ? 4'd3 : 4'd0));
        chk("bubstall.bub_cnt", 32'(bubble_cnt), 32'(PERF ? 4'd1 : 4'd0));

        // Stall timeout at the 4th stalled edge, sticky until flush
        do_reset("rstB");
        for (int k = 1; k <= 6; k++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 32'(k));
            chk($sformatf("timeout.stall%0d", k), 32'(stall_timeout), (k >= 4) ? 32'h1 : 32'h0);
        end
        chk("timeout.stl_cnt", 32'(stall_cnt), 32'(ecnt(6)));
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h22, 32'h0000_2222);
        chk("timeout.after_load", 32'(stall_timeout), 32'h1);
        chk("timeout.load_valid", 32'(out_valid), 32'h1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h33, 32'h0000_3333);
        chk("timeout.after_flush", 32'(stall_timeout), 32'h0);
        chk("timeout.flush_data", data_out, 32'h0000_2222);

        // Twenty bubbles saturate the 4-bit bubble counter
        do_reset("rstC");
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 32'(k));
            chk($sformatf("sat.bub%0d", k), 32'(bubble_cnt), 32'(ecnt(m_bub)));
            chk($sformatf("sat.stl%0d", k), 32'(stall_cnt), 32'h0);
        end
        chk("sat.final", 32'(bubble_cnt), 32'(PERF ? 4'hF : 4'h0));

        // Asynchronous reset in the middle of a stall
        do_reset("rstD");
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 32'h1234_5678);
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 32'h0);
        chk("midstall.held", data_out, 32'h1234_5678);
        #3;
        rst_n = 1'b0;
        m_bub = 0;
        m_stl = 0;
        #1;
        chk_zero("midrst");
        #2;
        rst_n = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'hEE, 32'hEEEE_EEEE);
        chk("postrst.valid",   32'(out_valid), 32'h0);
        chk("postrst.ctrl",    32'(ctrl_out), 32'h0);
        chk("postrst.data",    data_out, 32'h0);
        chk("postrst.stl_cnt", 32'(stall_cnt), 32'(ecnt(1)));
        chk("postrst.timeout", 32'(stall_timeout), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
